// File: rtl/memoria_responder.sv
// ---------------------------------------------------------------------------
// memoria_responder
//
// Memory-side responder for the multicycle CPU's instruction/data port.
// A request is accepted with a ReqValid/ReqReady handshake, optionally held
// for LATENCIA wait cycles, and answered with a one-cycle RespValid pulse.
// The store is word organised (2^ADDR_BITS x 32 bit) behind a byte-addressed
// interface; misaligned or out-of-range addresses are answered with Erro=1.
//
// Ports:
//   Clock        rising-edge system clock
//   Reset        asynchronous, active-low reset
//   ReqValid     CPU presents a request this cycle
//   ReqReady     responder can accept a request this cycle
//   Wr           1 = write, 0 = read (sampled with the request)
//   Address      byte address (sampled with the request)
//   DataIn       write data (sampled with the request)
//   RespValid    one-cycle pulse, response available
//   DataOut      read data or write echo, held until the next response
//   Erro         qualifies RespValid: misaligned or out-of-range access
//   ContLeituras completed non-error reads (wrapping)
//   ContEscritas completed non-error writes (wrapping)
// ---------------------------------------------------------------------------
module memoria_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCIA  = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic        RespValid,
    output logic [31:0] DataOut,
    output logic        Erro,
    output logic [15:0] ContLeituras,
    output logic [15:0] ContEscritas
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ESPERA   = 2'd1,
        RESPOSTA = 2'd2
    } state_t;

    // The wait counter counts down to zero, so it starts at LATENCIA-1.
    localparam logic [3:0] WAIT_LOAD = (LATENCIA > 0) ? 4'(LATENCIA - 1) : 4'd0;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic                   pend_wr;
    logic [31:0]            pend_addr;
    logic [31:0]            pend_data;
    logic [31:0]            mem [0:(2**ADDR_BITS)-1];

    logic                   accept;
    logic                   from_wait;
    logic                   enter_resp;
    logic                   eff_wr;
    logic [31:0]            eff_addr;
    logic [31:0]            eff_data;
    logic                   eff_err;
    logic [ADDR_BITS-1:0]   idx;

    // The transaction being completed comes from the latched request when
    // leaving ESPERA, or straight from the inputs when LATENCIA is zero and
    // the request is accepted and answered on the same edge.
    always_comb begin
        accept     = ReqValid && ReqReady;
        from_wait  = (state == ESPERA) && (wait_cnt == 4'd0);
        enter_resp = from_wait || (accept && (LATENCIA == 0));
        eff_wr     = from_wait ? pend_wr   : Wr;
        eff_addr   = from_wait ? pend_addr : Address;
        eff_data   = from_wait ? pend_data : DataIn;
        eff_err    = (eff_addr[1:0] != 2'b00) ||
                     ((eff_addr >> (ADDR_BITS + 2)) != 32'd0);
        idx        = eff_addr[ADDR_BITS+1:2];
    end

    // Handshake FSM plus response registers. Everything visible on the
    // response side only changes on the edge that enters RESPOSTA.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            ReqReady     <= 1'b1;
            RespValid    <= 1'b0;
            Erro         <= 1'b0;
            DataOut      <= 32'd0;
            ContLeituras <= 16'd0;
            ContEscritas <= 16'd0;
            wait_cnt     <= 4'd0;
            pend_wr      <= 1'b0;
            pend_addr    <= 32'd0;
            pend_data    <= 32'd0;
        end else begin
            RespValid <= enter_resp;

            case (state)
                IDLE, RESPOSTA: begin
                    if (accept) begin
                        pend_wr   <= Wr;
                        pend_addr <= Address;
                        pend_data <= DataIn;
                        if (LATENCIA > 0) begin
                            state    <= ESPERA;
                            wait_cnt <= WAIT_LOAD;
                            ReqReady <= 1'b0;
                        end else begin
                            state    <= RESPOSTA;
                            ReqReady <= 1'b1;
                        end
                    end else begin
                        state    <= IDLE;
                        ReqReady <= 1'b1;
                    end
                end
                ESPERA: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= RESPOSTA;
                        ReqReady <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ReqReady <= 1'b1;
                end
            endcase

            if (enter_resp) begin
                Erro <= eff_err;
                if (eff_err) begin
                    DataOut <= 32'd0;
                end else if (eff_wr) begin
                    DataOut      <= eff_data;
                    ContEscritas <= ContEscritas + 16'd1;
                end else begin
                    DataOut      <= mem[idx];
                    ContLeituras <= ContLeituras + 16'd1;
                end
            end
        end
    end

    // Store write port. The store is never cleared; a write only commits on
    // the edge entering RESPOSTA and never while Reset is held low, so an
    // aborted transaction leaves the store untouched.
    always_ff @(posedge Clock) begin
        if (Reset && enter_resp && eff_wr && !eff_err) begin
            mem[idx] <= eff_data;
        end
    end

endmodule

// File: tb/tb_memoria_responder.sv
// ---------------------------------------------------------------------------
// tb_memoria_responder
//
// Directed bench for memoria_responder. Three instances share one clock:
// unit 0 with LATENCIA=0, unit 1 with LATENCIA=2, unit 2 with LATENCIA=3.
// Latency is measured as the number of rising edges between the accepting
// edge and the edge after which RespValid is high, i.e. LATENCIA (response
// in cycle N+LATENCIA+1 when the request is presented in cycle N).
// ---------------------------------------------------------------------------
module tb_memoria_responder;

    logic        clock;
    logic        rst_n      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        wr         [3];
    logic [31:0] addr       [3];
    logic [31:0] din        [3];
    logic        resp_valid [3];
    logic [31:0] dout       [3];
    logic        erro       [3];
    logic [15:0] cont_rd    [3];
    logic [15:0] cont_wr    [3];

    int checks = 0;
    int errors = 0;

    memoria_responder #(.ADDR_BITS(8), .LATENCIA(0)) u_lat0 (
        .Clock(clock), .Reset(rst_n[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
        .Wr(wr[0]), .Address(addr[0]), .DataIn(din[0]), .RespValid(resp_valid[0]),
        .DataOut(dout[0]), .Erro(erro[0]), .ContLeituras(cont_rd[0]), .ContEscritas(cont_wr[0])
    );

    memoria_responder #(.ADDR_BITS(8), .LATENCIA(2)) u_lat2 (
        .Clock(clock), .Reset(rst_n[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
        .Wr(wr[1]), .Address(addr[1]), .DataIn(din[1]), .RespValid(resp_valid[1]),
        .DataOut(dout[1]), .Erro(erro[1]), .ContLeituras(cont_rd[1]), .ContEscritas(cont_wr[1])
    );

    memoria_responder #(.ADDR_BITS(8), .LATENCIA(3)) u_lat3 (
        .Clock(clock), .Reset(rst_n[2]), .ReqValid(req_valid[2]), .ReqReady(req_ready[2]),
        .Wr(wr[2]), .Address(addr[2]), .DataIn(din[2]), .RespValid(resp_valid[2]),
        .DataOut(dout[2]), .Erro(erro[2]), .ContLeituras(cont_rd[2]), .ContEscritas(cont_wr[2])
    );

    // Free-running 10-unit clock shared by all three instances.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One complete transaction on unit u: present the request, wait for it
    // to be accepted, then wait (bounded) for the response. lat is -1 when
    // no response appears.
    task automatic applyStimulus(input int u, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] rdata,
                                 output logic rerr, output int lat);
        int waited;
        @(negedge clock);
        req_valid[u] = 1'b1;
        wr[u]        = w;
        addr[u]      = a;
        din[u]       = d;
        waited = 0;
        while (!req_ready[u] && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready[u]) checkOutput("ready_timeout", 32'(req_ready[u]), 32'd1);
        @(posedge clock);
        #1;
        req_valid[u] = 1'b0;
        lat = 0;
        while (!resp_valid[u] && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!resp_valid[u]) lat = -1;
        rdata = dout[u];
        rerr  = erro[u];
    endtask

    initial begin
        logic [31:0] rdata;
        logic        rerr;
        int          lat;
        logic        w_seq [6];
        logic [31:0] a_seq [6];
        logic [31:0] d_seq [6];
        logic [31:0] e_seq [6];

        for (int u = 0; u < 3; u++) begin
            rst_n[u] = 1'b0; req_valid[u] = 1'b0; wr[u] = 1'b0;
            addr[u] = 32'd0; din[u] = 32'd0;
        end
        repeat (2) @(posedge clock);
        #1;

        // Reset values on every unit.
        for (int u = 0; u < 3; u++) begin
            checkOutput("rst_ready", 32'(req_ready[u]), 32'd1);
            checkOutput("rst_resp",  32'(resp_valid[u]), 32'd0);
            checkOutput("rst_erro",  32'(erro[u]), 32'd0);
            checkOutput("rst_dout",  dout[u], 32'd0);
            checkOutput("rst_cnt_rd", 32'(cont_rd[u]), 32'd0);
            checkOutput("rst_cnt_wr", 32'(cont_wr[u]), 32'd0);
        end
        @(negedge clock);
        for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;

        // LATENCIA=2: write then read back one word.
        applyStimulus(1, 1'b1, 32'h10, 32'hDEADBEEF, rdata, rerr, lat);
        checkOutput("l2_wr_lat",  32'(lat), 32'd2);
        checkOutput("l2_wr_echo", rdata, 32'hDEADBEEF);
        checkOutput("l2_wr_erro", 32'(rerr), 32'd0);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, rdata, rerr, lat);
        checkOutput("l2_rd_lat",  32'(lat), 32'd2);
        checkOutput("l2_rd_data", rdata, 32'hDEADBEEF);
        checkOutput("l2_rd_erro", 32'(rerr), 32'd0);
        @(posedge clock); #1;
        checkOutput("l2_resp_pulse", 32'(resp_valid[1]), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("l2_dout_hold", dout[1], 32'hDEADBEEF);
        checkOutput("l2_cnt_rd", 32'(cont_rd[1]), 32'd1);
        checkOutput("l2_cnt_wr", 32'(cont_wr[1]), 32'd1);

        // Misaligned and out-of-range accesses report Erro, leave counters.
        applyStimulus(1, 1'b0, 32'h13, 32'h0, rdata, rerr, lat);
        checkOutput("mis_lat",  32'(lat), 32'd2);
        checkOutput("mis_erro", 32'(rerr), 32'd1);
        checkOutput("mis_dout", rdata, 32'd0);
        applyStimulus(1, 1'b0, 32'h400, 32'h0, rdata, rerr, lat);
        checkOutput("oor_erro", 32'(rerr), 32'd1);
        checkOutput("oor_dout", rdata, 32'd0);
        applyStimulus(1, 1'b1, 32'h410, 32'hCAFEF00D, rdata, rerr, lat);
        checkOutput("oor_wr_erro", 32'(rerr), 32'd1);
        checkOutput("oor_wr_dout", rdata, 32'd0);
        checkOutput("err_cnt_rd", 32'(cont_rd[1]), 32'd1);
        checkOutput("err_cnt_wr", 32'(cont_wr[1]), 32'd1);
        // 0x410 aliases word 4 (0x10) in the low bits; it must not have landed.
        applyStimulus(1, 1'b0, 32'h10, 32'h0, rdata, rerr, lat);
        checkOutput("oor_no_alias", rdata, 32'hDEADBEEF);

        // LATENCIA=0: ReqValid held high, one response per cycle.
        w_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        a_seq = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
        d_seq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h0, 32'h0, 32'h0};
        e_seq = '{32'h11111111, 32'h22222222, 32'h33333333,
                  32'h11111111, 32'h22222222, 32'h33333333};
        @(negedge clock);
        req_valid[0] = 1'b1; wr[0] = w_seq[0]; addr[0] = a_seq[0]; din[0] = d_seq[0];
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("b2b_resp%0d", i), 32'(resp_valid[0]), 32'd1);
            checkOutput($sformatf("b2b_dout%0d", i), dout[0], e_seq[i]);
            checkOutput($sformatf("b2b_ready%0d", i), 32'(req_ready[0]), 32'd1);
            if (i < 5) begin
                wr[0] = w_seq[i+1]; addr[0] = a_seq[i+1]; din[0] = d_seq[i+1];
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        @(posedge clock); #1;
        checkOutput("b2b_idle", 32'(resp_valid[0]), 32'd0);
        checkOutput("b2b_cnt_rd", 32'(cont_rd[0]), 32'd3);
        checkOutput("b2b_cnt_wr", 32'(cont_wr[0]), 32'd3);

        // Read counter wrap: 65533 more reads take it from 3 through FFFF to 0.
        @(negedge clock);
        req_valid[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0;
        repeat (65532) @(posedge clock);
        @(negedge clock);
        checkOutput("wrap_ffff", 32'(cont_rd[0]), 32'h0000FFFF);
        @(posedge clock);
        @(negedge clock);
        req_valid[0] = 1'b0;
        checkOutput("wrap_zero", 32'(cont_rd[0]), 32'd0);
        checkOutput("wrap_cnt_wr", 32'(cont_wr[0]), 32'd3);

        // LATENCIA=3: seed a word, then abort a write to it with reset.
        applyStimulus(2, 1'b1, 32'h20, 32'hA5A5A5A5, rdata, rerr, lat);
        checkOutput("l3_seed_lat", 32'(lat), 32'd3);
        @(negedge clock);
        req_valid[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h20; din[2] = 32'h12345678;
        @(posedge clock);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clock);
        #1;
        rst_n[2] = 1'b0;
        #1;
        checkOutput("abort_ready",  32'(req_ready[2]), 32'd1);
        checkOutput("abort_resp",   32'(resp_valid[2]), 32'd0);
        checkOutput("abort_erro",   32'(erro[2]), 32'd0);
        checkOutput("abort_dout",   dout[2], 32'd0);
        checkOutput("abort_cnt_wr", 32'(cont_wr[2]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("abort_noresp%0d", k), 32'(resp_valid[2]), 32'd0);
            if (k == 1) rst_n[2] = 1'b1;
        end
        applyStimulus(2, 1'b0, 32'h20, 32'h0, rdata, rerr, lat);
        checkOutput("abort_rd_lat",  32'(lat), 32'd3);
        checkOutput("abort_rd_data", rdata, 32'hA5A5A5A5);

        // Requests presented during ESPERA are ignored.
        @(negedge clock);
        req_valid[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h20; din[2] = 32'h0;
        @(posedge clock);
        #1;
        req_valid[2] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            checkOutput($sformatf("espera_ready%0d", c), 32'(req_ready[2]), 32'd0);
            checkOutput($sformatf("espera_resp%0d", c), 32'(resp_valid[2]), 32'd0);
            if (c == 2) begin
                req_valid[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h24; din[2] = 32'h0BAD0BAD;
            end
            if (c == 3) req_valid[2] = 1'b0;
        end
        @(posedge clock); #1;
        checkOutput("espera_resp", 32'(resp_valid[2]), 32'd1);
        checkOutput("espera_data", dout[2], 32'hA5A5A5A5);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            checkOutput($sformatf("espera_noextra%0d", k), 32'(resp_valid[2]), 32'd0);
        end
        checkOutput("espera_cnt_rd", 32'(cont_rd[2]), 32'd2);
        checkOutput("espera_cnt_wr", 32'(cont_wr[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
